// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Execute-stage ALU with valid/ready handshakes on both sides. Each accepted
//   operation is evaluated combinationally from SrcA/SrcB/ALUCtl and stored,
//   together with its Zero/Overflow/Illegal flags, in a 2-entry result FIFO
//   so downstream backpressure never drops a result.
//
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     flush            synchronous flush; empties the buffer, drops same-cycle push
//     in_valid/in_ready    upstream handshake (in_ready depends on state only)
//     ALUCtl, SrcA, SrcB   operation code and operands
//     out_valid/out_ready  downstream handshake
//     ALUResult, Zero, Overflow, Illegal   head-of-buffer result and flags
//                                          (all driven 0 when the buffer is empty)
//
//   Optional feature macro: ALU_EXEC_NOR_EN enables ALUCtl 4'b1100 as NOR.
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUCtl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal
);

    // Entry layout: {result, zero, overflow, illegal}
    localparam int EW = WIDTH + 3;

    // Evaluate one operation into a packed buffer entry.
    function automatic logic [EW-1:0] alu_eval(
        input logic [3:0]       ctl,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] res;
        logic             add_ovf;
        logic             sub_ovf;
        logic             lt;
        logic             ovf;
        logic             ill;
        sum     = a + b;
        diff    = a - b;
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
        // Sign of the difference corrected for overflow gives a true signed compare.
        lt      = diff[WIDTH-1] ^ sub_ovf;
        res     = {WIDTH{1'b0}};
        ovf     = 1'b0;
        ill     = 1'b0;
        case (ctl)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: begin
                res = sum;
                ovf = add_ovf;
            end
            4'b0110: begin
                res = diff;
                ovf = sub_ovf;
            end
            4'b0111: res = {{(WIDTH-1){1'b0}}, lt};
`ifdef ALU_EXEC_NOR_EN
            4'b1100: res = ~(a | b);
`endif
            default: begin
                res = {WIDTH{1'b0}};
                ill = 1'b1;
            end
        endcase
        return {res, (res == {WIDTH{1'b0}}), ovf, ill};
    endfunction

    logic [1:0]    count_r;
    logic          wr_ptr_r;
    logic          rd_ptr_r;
    logic [EW-1:0] mem_r [2];

    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] entry_s;
    logic [EW-1:0] head_s;

    // Handshake decode; in_ready comes only from registered occupancy.
    always_comb begin
        in_ready  = (count_r != 2'd2);
        out_valid = (count_r != 2'd0);
        push_s    = in_valid & in_ready;
        pop_s     = out_valid & out_ready;
        entry_s   = alu_eval(ALUCtl, SrcA, SrcB);
    end

    // Buffer state: async reset, flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            mem_r[0] <= {EW{1'b0}};
            mem_r[1] <= {EW{1'b0}};
        end else if (flush) begin
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Present the head entry; force zeros when nothing is buffered.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (out_valid) begin
            {ALUResult, Zero, Overflow, Illegal} = head_s;
        end else begin
            {ALUResult, Zero, Overflow, Illegal} = {EW{1'b0}};
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//   Directed test-plan steps followed by randomized traffic, all checked
//   against a queue-based reference model of the result buffer.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUCtl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Overflow;
    logic        Illegal;

    int checks = 0;
    int errors = 0;

    // Expected buffer contents, head at index 0: {result, zero, ovf, illegal}
    logic [34:0] q[$];

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUCtl(ALUCtl), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .Overflow(Overflow), .Illegal(Illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: signed arithmetic on 64-bit integers, overflow = out of 32-bit range.
    function automatic logic [34:0] ref_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        logic [31:0] res;
        logic ov;
        logic ill;
        sa  = $signed(a);
        sb  = $signed(b);
        ov  = 1'b0;
        ill = 1'b0;
        res = 32'd0;
        case (ctl)
            4'd0: res = a & b;
            4'd1: res = a | b;
            4'd2: begin
                r = sa + sb;
                res = r[31:0];
                ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd6: begin
                r = sa - sb;
                res = r[31:0];
                ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd7: res = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_EXEC_NOR_EN
            4'd12: res = ~(a | b);
`endif
            default: begin
                res = 32'd0;
                ill = 1'b1;
            end
        endcase
        return {res, (res == 32'd0), ov, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [34:0] h;
        logic        v;
        v = (q.size() != 0);
        h = v ? q[0] : 35'd0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, v});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() != 2)});
        chk("ALUResult", ALUResult, h[34:3]);
        chk("Zero", {31'd0, Zero}, {31'd0, h[2]});
        chk("Overflow", {31'd0, Overflow}, {31'd0, h[1]});
        chk("Illegal", {31'd0, Illegal}, {31'd0, h[0]});
    endtask

    // One clock with the currently driven inputs; update model, then check.
    task automatic cycle();
        bit          push;
        bit          pop;
        logic [34:0] e;
        push = in_valid && (q.size() < 2);
        pop  = (q.size() > 0) && out_ready;
        e    = ref_op(ALUCtl, SrcA, SrcB);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) q.delete(0);
            if (push) q.push_back(e);
        end
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        ALUCtl   = c;
        SrcA     = a;
        SrcB     = b;
    endtask

    initial begin
        logic [3:0] ctls [7];
        ctls = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd5};
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_outputs();

        // ADD overflow
        out_ready = 1'b1;
        drive(1'b1, 4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        cycle();
        chk("add_res", ALUResult, 32'h8000_0000);
        chk("add_ovf", {31'd0, Overflow}, 32'd1);
        drive(1'b1, 4'd6, 32'd5, 32'd5);
        cycle();
        chk("sub_zero", {31'd0, Zero}, 32'd1);
        drive(1'b1, 4'd7, 32'h8000_0000, 32'h0000_0001);
        cycle();
        chk("slt_neg", ALUResult, 32'd1);
        drive(1'b1, 4'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        cycle();
        chk("slt_pos", ALUResult, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        cycle();

        // Fill under backpressure, third op held upstream
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 32'h0000_F0F0, 32'h0000_FF00);
        cycle();
        drive(1'b1, 4'd1, 32'h0000_000F, 32'h0000_00F0);
        cycle();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 4'd2, 32'd10, 32'd20);
        cycle();
        cycle();
        chk("stall_head", ALUResult, 32'h0000_F000);
        out_ready = 1'b1;
        cycle();
        chk("second_head", ALUResult, 32'h0000_00FF);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        cycle();
        cycle();
        cycle();

        // Simultaneous push/pop at count 1
        out_ready = 1'b0;
        drive(1'b1, 4'd2, 32'd1, 32'd1);
        cycle();
        out_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            drive(1'b1, 4'd2, i, i);
            cycle();
            chk("pp_in_ready", {31'd0, in_ready}, 32'd1);
            chk("pp_result", ALUResult, 32'(2 * i));
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        cycle();
        cycle();

        // Flush a full buffer with an incoming op
        out_ready = 1'b0;
        drive(1'b1, 4'd1, 32'h1234_0000, 32'h0000_5678);
        cycle();
        cycle();
        flush = 1'b1;
        drive(1'b1, 4'd2, 32'd7, 32'd8);
        cycle();
        flush = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1) == 1, ctls[$urandom_range(0, 6)], $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) ALUCtl = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) SrcB = SrcA;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        cycle();
        cycle();

        // NOR code, then reset while stalled
        out_ready = 1'b0;
        drive(1'b1, 4'd12, 32'd0, 32'd0);
        cycle();
`ifdef ALU_EXEC_NOR_EN
        chk("nor_res", ALUResult, 32'hFFFF_FFFF);
        chk("nor_ill", {31'd0, Illegal}, 32'd0);
`else
        chk("nor_res", ALUResult, 32'd0);
        chk("nor_ill", {31'd0, Illegal}, 32'd1);
        chk("nor_zero", {31'd0, Zero}, 32'd1);
`endif
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", ALUResult, 32'd0);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
